// File: rtl/router_dest_reader.sv
`default_nettype none
// ============================================================================
// Module   : router_dest_reader
// Function : Destination-side reader that drains one packet per vld_out burst.
// Revision : 1.0
// ============================================================================
module router_dest_reader #(
  parameter int         RD_DELAY = 4,
  parameter logic [1:0] PORT_ID  = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       soft_reset,
  output logic       read_enb,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [5:0] pkt_len,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic       pkt_abort,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int         WAIT_LAST   = (RD_DELAY > 0) ? RD_DELAY - 1 : 0;
  localparam logic [4:0] C_WAIT_LAST = WAIT_LAST[4:0];

  logic [1:0] r_state;
  logic [4:0] r_wait;
  logic [6:0] r_issued;
  logic [6:0] r_target;
  logic [6:0] r_caps;
  logic       r_cap_pend;
  logic [7:0] r_acc;
  logic [1:0] r_addr;
  logic       r_err;
  logic       r_abort;
  logic       r_valid;
  logic [7:0] r_byte;
  logic [5:0] r_len;

  logic w_read_ok;
  logic w_last;

  // Until the header is seen the target is 2 reads, which covers a zero-length packet exactly.
  assign w_read_ok = (r_state == S_READ) && (r_issued < r_target) && !soft_reset;
  assign read_enb  = w_read_ok & vld_out;
  assign w_last    = (r_caps != 7'd0) && (r_caps == ({1'b0, r_len} + 7'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait     <= 5'd0;
      r_issued   <= 7'd0;
      r_target   <= 7'd2;
      r_caps     <= 7'd0;
      r_cap_pend <= 1'b0;
      r_acc      <= 8'h00;
      r_addr     <= 2'd0;
      r_err      <= 1'b0;
      r_abort    <= 1'b0;
      r_valid    <= 1'b0;
      r_byte     <= 8'h00;
      r_len      <= 6'd0;
    end else begin
      r_valid <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wait     <= 5'd0;
          r_issued   <= 7'd0;
          r_target   <= 7'd2;
          r_caps     <= 7'd0;
          r_cap_pend <= 1'b0;
          if (vld_out) begin
            r_state <= (RD_DELAY == 0) ? S_READ : S_WAIT;
          end
        end
        S_WAIT: begin
          if (soft_reset) begin
            r_abort <= 1'b1;
            r_state <= S_IDLE;
          end else if (!vld_out) begin
            r_state <= S_IDLE;
          end else if (r_wait == C_WAIT_LAST) begin
            r_state <= S_READ;
          end else begin
            r_wait <= r_wait + 5'd1;
          end
        end
        S_READ: begin
          if (soft_reset) begin
            r_abort    <= 1'b1;
            r_cap_pend <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_cap_pend <= read_enb;
            if (read_enb) begin
              r_issued <= r_issued + 7'd1;
            end
            if (r_cap_pend) begin
              r_caps <= r_caps + 7'd1;
              if (r_caps == 7'd0) begin
                r_len    <= data_out[7:2];
                r_addr   <= data_out[1:0];
                r_acc    <= data_out;
                r_target <= {1'b0, data_out[7:2]} + 7'd2;
              end else if (w_last) begin
                r_err   <= (r_acc != data_out) | (r_addr != PORT_ID);
                r_state <= S_DONE;
              end else begin
                r_byte  <= data_out;
                r_valid <= 1'b1;
                r_acc   <= r_acc ^ data_out;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign byte_out   = r_byte;
  assign byte_valid = r_valid;
  assign pkt_len    = r_len;
  assign pkt_done   = (r_state == S_DONE);
  assign pkt_err    = (r_state == S_DONE) & r_err;
  assign pkt_abort  = r_abort;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
